// File: rtl/data_mem.sv
// rtl/data_mem.sv - RISC-V data memory with byte-lane stores, extended loads, fault reporting and GPIO outputs
// Contents are zeroed word by word after every reset before requests are accepted.
module data_mem #(
    parameter int          ADDR_WIDTH    = 12,
    parameter int          GPIO_CHANNELS = 1,
    parameter logic [31:0] GPIO_BASE     = 32'h0000_1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [1:0]                   req_size,
    input  logic                         req_unsigned,
    input  logic [31:0]                  req_addr,
    input  logic [31:0]                  req_wdata,
    output logic                         rsp_valid,
    output logic [31:0]                  rsp_rdata,
    output logic                         rsp_fault,
    output logic [8*GPIO_CHANNELS-1:0]   gpio
);

    localparam int          IDX_W    = ADDR_WIDTH - 2;
    localparam int          DEPTH    = 1 << IDX_W;
    localparam logic [32:0] GPIO_END = {1'b0, GPIO_BASE} + 33'(4 * GPIO_CHANNELS);

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_t;

    state_t                       state_q, state_d;
    logic [IDX_W-1:0]             clr_cnt_q, clr_cnt_d;
    logic [8*GPIO_CHANNELS-1:0]   gpio_q, gpio_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic                         rsp_fault_q, rsp_fault_d;
    logic [31:0]                  rsp_rdata_q, rsp_rdata_d;
    logic [31:0]                  mem_q [DEPTH];

    logic                         accept;
    logic                         in_gpio;
    logic                         in_ram;
    logic                         misalign;
    logic                         fault;
    logic [IDX_W-1:0]             word_idx;
    logic [31:0]                  rd_word;
    logic [7:0]                   ld_byte;
    logic [15:0]                  ld_half;
    logic [31:0]                  ld_ext;
    logic [29:0]                  gpio_ch;
    logic [7:0]                   gpio_rd;
    logic [3:0]                   lane_be;
    logic [31:0]                  wr_data;
    logic                         ram_we;
    logic                         clr_we;

    assign accept   = req_valid && (state_q == ST_READY);
    assign in_gpio  = ({1'b0, req_addr} >= {1'b0, GPIO_BASE}) && ({1'b0, req_addr} < GPIO_END);
    assign in_ram   = (req_addr >> ADDR_WIDTH) == 32'd0;
    assign word_idx = req_addr[ADDR_WIDTH-1:2];
    assign rd_word  = mem_q[word_idx];
    assign gpio_ch  = 30'((req_addr - GPIO_BASE) >> 2);

    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'd1:    misalign = req_addr[0];
            2'd2:    misalign = (req_addr[1:0] != 2'd0);
            default: misalign = 1'b0;
        endcase
    end

    // GPIO channels are word-spaced, so any unaligned access in the window faults
    assign fault = (req_size == 2'd3) || misalign
                || (in_gpio && (req_addr[1:0] != 2'd0))
                || (!in_gpio && !in_ram);

    always_comb begin
        gpio_rd = 8'd0;
        for (int k = 0; k < GPIO_CHANNELS; k++) begin
            if (gpio_ch == 30'(k)) gpio_rd = gpio_q[8*k +: 8];
        end
    end

    always_comb begin
        ld_byte = 8'd0;
        case (req_addr[1:0])
            2'd0: ld_byte = rd_word[7:0];
            2'd1: ld_byte = rd_word[15:8];
            2'd2: ld_byte = rd_word[23:16];
            2'd3: ld_byte = rd_word[31:24];
            default: ld_byte = 8'd0;
        endcase
        ld_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
        ld_ext  = rd_word;
        if (req_size == 2'd0) begin
            ld_ext = req_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
        end else if (req_size == 2'd1) begin
            ld_ext = req_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
        end
    end

    // Store data is replicated across lanes; the byte enables pick the live ones
    always_comb begin
        lane_be = 4'b0000;
        wr_data = req_wdata;
        case (req_size)
            2'd0: begin
                lane_be = 4'b0001 << req_addr[1:0];
                wr_data = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                lane_be = req_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            2'd2: lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        gpio_d      = gpio_q;
        rsp_valid_d = accept;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = 32'd0;
        ram_we      = 1'b0;
        clr_we      = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + IDX_W'(1);
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
            end
            ST_READY: begin
                if (accept) begin
                    if (fault) begin
                        rsp_fault_d = 1'b1;
                    end else if (in_gpio) begin
                        if (req_we) begin
                            for (int k = 0; k < GPIO_CHANNELS; k++) begin
                                if (gpio_ch == 30'(k)) gpio_d[8*k +: 8] = req_wdata[7:0];
                            end
                        end else begin
                            rsp_rdata_d = {24'd0, gpio_rd};
                        end
                    end else if (req_we) begin
                        ram_we = 1'b1;
                    end else begin
                        rsp_rdata_d = ld_ext;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            gpio_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            gpio_q      <= gpio_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // RAM array carries no reset; it is zeroed by the clear sequence instead
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= 32'd0;
        end else if (ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_be[l]) mem_q[word_idx][8*l +: 8] <= wr_data[8*l +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_READY);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign gpio      = gpio_q;

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - self-checking bench for data_mem against a byte-array reference model
module tb_data_mem;

    localparam int          AW    = 12;
    localparam int          CH    = 2;
    localparam logic [31:0] GB    = 32'h0000_1000;
    localparam int          DEPTH = 1 << (AW - 2);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [8*CH-1:0] gpio;

    int total = 0;
    int bad   = 0;

    data_mem #(.ADDR_WIDTH(AW), .GPIO_CHANNELS(CH), .GPIO_BASE(GB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .gpio(gpio)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed RAM, per-channel GPIO bytes, edge count since reset
    logic [7:0]  m_mem [1 << AW];
    logic [7:0]  m_gpio [CH];
    int          m_edges = 0;
    bit          m_ready = 1'b0;
    bit          exp_valid = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_fault = 1'b0;

    task automatic model_access(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic flt);
        longint ua;
        bit     in_g, in_r;
        int     ch;
        logic [31:0] v;
        ua   = longint'(a);
        in_g = (ua >= longint'(GB)) && (ua < longint'(GB) + 4 * CH);
        in_r = ua < (longint'(1) << AW);
        rd   = 32'd0;
        flt  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
            || (in_g && a[1:0] != 2'd0) || (!in_g && !in_r);
        if (!flt && in_g) begin
            ch = int'((a - GB) / 4);
            if (we) m_gpio[ch] = wd[7:0];
            else    rd = {24'd0, m_gpio[ch]};
        end else if (!flt) begin
            v = 32'd0;
            for (int i = 0; i < (1 << sz); i++) begin
                if (we) m_mem[int'(a) + i] = wd[8*i +: 8];
                else    v = v | (32'(m_mem[int'(a) + i]) << (8 * i));
            end
            if (!we) begin
                if (sz == 2'd0)      rd = (!uns && v[7])  ? (v | 32'hFFFF_FF00) : v;
                else if (sz == 2'd1) rd = (!uns && v[15]) ? (v | 32'hFFFF_0000) : v;
                else                 rd = v;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] rd;
        logic        flt;
        if (!rst_n) begin
            m_edges   = 0;
            m_ready   = 1'b0;
            exp_valid = 1'b0;
            exp_rdata = 32'd0;
            exp_fault = 1'b0;
            foreach (m_mem[i]) m_mem[i] = 8'd0;
            foreach (m_gpio[i]) m_gpio[i] = 8'd0;
        end else begin
            if (m_ready && req_valid) begin
                model_access(req_we, req_size, req_unsigned, req_addr, req_wdata, rd, flt);
                exp_valid = 1'b1;
                exp_rdata = rd;
                exp_fault = flt;
            end else begin
                exp_valid = 1'b0;
            end
            if (!m_ready) begin
                m_edges++;
                if (m_edges == DEPTH) m_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [8*CH-1:0] g;
        for (int k = 0; k < CH; k++) g[8*k +: 8] = m_gpio[k];
        check("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
        check("gpio", 32'(gpio), 32'(g));
        if (exp_valid) begin
            check("rsp_rdata", rsp_rdata, exp_rdata);
            check("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_fault});
        end
    end

    logic        got_valid;
    logic [31:0] got_rdata;
    logic        got_fault;

    task automatic req(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        got_valid = rsp_valid;
        got_rdata = rsp_rdata;
        got_fault = rsp_fault;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (n < 3000) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ready) break;
        end
        check(name, 32'(n), 32'(DEPTH));
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_fault", {31'd0, rsp_fault}, 32'd0);
        check("rst_gpio", 32'(gpio), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        wait_ready("clear_edges");

        req(1, 2'd0, 0, 32'h101, 32'h0000_0080);
        req(0, 2'd0, 0, 32'h101, 32'd0);  check("lb_signed", got_rdata, 32'hFFFF_FF80);
        req(0, 2'd0, 1, 32'h101, 32'd0);  check("lb_unsigned", got_rdata, 32'h0000_0080);
        req(0, 2'd2, 0, 32'h100, 32'd0);  check("lw_100", got_rdata, 32'h0000_8000);
        req(1, 2'd1, 0, 32'h102, 32'h0000_ABCD);
        req(0, 2'd2, 0, 32'h100, 32'd0);  check("lw_100_half", got_rdata, 32'hABCD_8000);
        req(0, 2'd1, 0, 32'h102, 32'd0);  check("lh_signed", got_rdata, 32'hFFFF_ABCD);
        req(0, 2'd1, 1, 32'h102, 32'd0);  check("lh_unsigned", got_rdata, 32'h0000_ABCD);

        req(1, 2'd2, 0, 32'h000, 32'h1122_3344);
        req(1, 2'd1, 0, 32'h003, 32'h0000_BEEF);
        check("mis_fault", {31'd0, got_fault}, 32'd1);
        check("mis_rdata", got_rdata, 32'd0);
        req(0, 2'd2, 0, 32'h000, 32'd0);  check("lw_0_kept", got_rdata, 32'h1122_3344);
        req(0, 2'd1, 0, 32'h002, 32'd0);  check("lh_2", got_rdata, 32'h0000_1122);
        req(0, 2'd3, 0, 32'h000, 32'd0);  check("size3_fault", {31'd0, got_fault}, 32'd1);
        idle();

        req(1, 2'd2, 0, 32'h1004, 32'h1234_56A5);
        check("gpio_ch1", {24'd0, gpio[15:8]}, 32'h0000_00A5);
        req(0, 2'd0, 0, 32'h1004, 32'd0); check("gpio_load", got_rdata, 32'h0000_00A5);
        req(0, 2'd2, 0, 32'h1008, 32'd0); check("gpio_oob", {31'd0, got_fault}, 32'd1);
        req(1, 2'd0, 0, 32'h1001, 32'hFF);check("gpio_mis", {31'd0, got_fault}, 32'd1);
        req(0, 2'd2, 0, 32'h2000, 32'd0); check("far_fault", {31'd0, got_fault}, 32'd1);
        idle();

        req(1, 2'd2, 0, 32'h010, 32'hDEAD_BEEF);
        check("b2b_v1", {31'd0, got_valid}, 32'd1);
        req(0, 2'd2, 0, 32'h010, 32'd0);
        check("b2b_v2", {31'd0, got_valid}, 32'd1);
        check("b2b_data", got_rdata, 32'hDEAD_BEEF);

        req(1, 2'd2, 0, 32'h3FC, 32'hCAFE_F00D);
        req(1, 2'd0, 0, 32'h1000, 32'h5A);
        idle();
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check("async_gpio", 32'(gpio), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h1000; req_wdata = 32'hFF;
        repeat (300) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        wait_ready("reclear_edges");
        check("midclr_gpio", 32'(gpio), 32'd0);
        req(0, 2'd2, 0, 32'h3FC, 32'd0);  check("lw_3fc_zero", got_rdata, 32'd0);
        idle();
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem.md
# data_mem

Parametrised data memory for the RISC-V core. It adds a valid/ready request port, byte/half/word stores through byte lanes, and signed or unsigned loads. Misaligned and out-of-range accesses are reported as faults. A bank of memory-mapped 8-bit GPIO output channels sits outside the RAM range. Contents are zeroed by a hardware clear sequence after every reset. The block sits between the core's load/store unit and the board GPIO pins, and replaces the fixed 4 KiB RAM.

## Interface

Parameters:
- ADDR_WIDTH, 12, byte-address width of RAM; DEPTH = 2^(ADDR_WIDTH-2) words
- GPIO_CHANNELS, 1, number of 8-bit GPIO output registers (1..8)
- GPIO_BASE, 32'h0000_1000, byte address of channel 0; channel k at GPIO_BASE + 4*k

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  load data, extended to 32 bits; 0 for stores and faults
- rsp_fault  out  1  access faulted; qualified by rsp_valid
- gpio  out  8*GPIO_CHANNELS  channel k drives bits [8k+7:8k]

## Operation

- States: CLEAR, READY. Reset forces CLEAR with the word counter at 0.
  - CLEAR writes 0 to word[counter] each cycle and increments the counter.
  - After word DEPTH-1 is written, the block moves to READY. It stays in READY until the next reset.
- req_ready = (state == READY). A request is accepted on a clock edge where req_valid && req_ready.
- Decode order for an accepted request:
  1. GPIO window: GPIO_BASE <= addr < GPIO_BASE + 4*GPIO_CHANNELS.
  2. RAM: addr < 2^ADDR_WIDTH.
  3. Anything else faults.
- Fault conditions:
  - req_size == 3.
  - Half access with addr[0] = 1.
  - Word access with addr[1:0] != 0.
  - GPIO access with addr[1:0] != 0.
  - Address outside both the GPIO window and RAM.
- A faulted request changes no state and still produces a response with rsp_fault = 1 and rsp_rdata = 0.
- RAM store updates only the addressed byte lanes of word addr[ADDR_WIDTH-1:2]:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- RAM load selects the lane(s) named by addr and size, then extends them to 32 bits according to req_unsigned.
- GPIO store writes req_wdata[7:0] to channel (addr - GPIO_BASE) >> 2, for any legal size.
- GPIO load returns {24'b0, channel value}, independent of req_size and req_unsigned.
- Every accepted request, load or store, produces exactly one response.

## Timing

- Reset values: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_fault = 0, gpio = 0, state = CLEAR.
  - Reset clears GPIO registers immediately (asynchronous). RAM clearing is sequential.
- The clear sequence takes exactly DEPTH rising edges after rst_n deasserts. req_ready rises after edge DEPTH.
- Latency is 1 cycle: a request accepted at edge N gives rsp_valid = 1 for the cycle after edge N. rsp_valid then drops at edge N+1 unless another request is accepted there.
- Throughput is one request per cycle; there is no response backpressure.
- Store effects are visible at edge N:
  - GPIO pins change in the cycle after edge N.
  - A load accepted at edge N+1 to the same address returns the new data.
- Reset asserted during CLEAR or READY aborts everything at once: any pending response is dropped and the clear restarts from word 0.
- req_* inputs are ignored while req_ready = 0; no request is queued.

## Test plan

- **Reset clear:** with DEPTH = 1024, pre-store nonzero data, then pulse rst_n.
  - req_ready stays 0 for 1024 edges and goes 1 after edge 1024.
  - A word load at 0x3FC returns 0x00000000.
- **Byte store and extension:** store byte 0x80 at 0x101.
  - Signed byte load at 0x101 returns 0xFFFFFF80.
  - Unsigned byte load at 0x101 returns 0x00000080.
  - Word load at 0x100 returns 0x00008000.
- **Misalignment:** half store of 0xBEEF at 0x003.
  - Response has rsp_fault = 1 and rsp_rdata = 0.
  - A following word load at 0x000 returns its previous value, unchanged.
- **GPIO:** with GPIO_CHANNELS = 2, word store 0x1234_56A5 at 0x1004.
  - gpio[15:8] = 0xA5 the cycle after the store.
  - A load at 0x1004 returns 0x000000A5.
  - A load at 0x1008 faults.
- **Back-to-back:** word store 0xDEADBEEF at 0x010 at edge N, word load at 0x010 at edge N+1.
  - rsp_valid is high for 2 consecutive cycles.
  - The second response returns 0xDEADBEEF.
- **Reset mid-clear:** assert rst_n low 300 edges into CLEAR, then release.
  - req_ready rises only after a further 1024 edges.
  - gpio reads 0 throughout.
